// File: rtl/sdram_arbiter.sv
// ============================================================================
// Module      : sdram_arbiter
// Description : Two-port slot arbiter (core / loader) in front of a
//               single-access SDRAM controller. Optional loader fairness
//               is enabled with the SDRAM_ARB_FAIR_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_arbiter #(
    parameter int DATA_DLY = 6,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clkref,
    input  logic        ram_ready,

    input  logic        c_req,
    input  logic [24:0] c_addr,
    input  logic        c_we,
    input  logic        c_aux,
    input  logic [7:0]  c_din,
    output logic [15:0] c_dout,
    output logic        c_ack,

    input  logic        l_req,
    input  logic [24:0] l_addr,
    input  logic        l_we,
    input  logic        l_aux,
    input  logic [7:0]  l_din,
    output logic [15:0] l_dout,
    output logic        l_ack,

    output logic [24:0] sd_addr,
    output logic        sd_we,
    output logic        sd_aux,
    output logic [7:0]  sd_din,
    input  logic [15:0] sd_dout,

    output logic        busy,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAIT = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_CORE = 2'b01;
    localparam logic [1:0] GNT_LDR  = 2'b10;
    localparam logic [3:0] CNT_DONE = 4'(DATA_DLY);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_clkref_d;
    logic [3:0]  r_cnt;
    logic [24:0] r_sd_addr;
    logic        r_sd_we;
    logic        r_sd_aux;
    logic [7:0]  r_sd_din;
    logic [15:0] r_c_dout;
    logic [15:0] r_l_dout;
    logic        r_c_ack;
    logic        r_l_ack;
    logic        r_busy;
    logic [1:0]  r_grant;

    logic        w_slot_start;
    logic        w_grant_go;
    logic        w_done;
    logic        w_pick_c;
    logic        w_pick_l;

    assign w_slot_start = clkref & ~r_clkref_d;
    assign w_grant_go   = (r_state == ST_WAIT) && ram_ready && w_slot_start;
    assign w_done       = (r_state == ST_BUSY) && (r_cnt == CNT_DONE);

`ifdef SDRAM_ARB_FAIR_EN
    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    logic [3:0] r_wait;
    logic       w_force_l;

    // A starved loader overrides core priority once it has lost MAX_WAIT slots
    assign w_force_l = l_req && (r_wait >= WAIT_LIM);
    assign w_pick_c  = c_req && !w_force_l;
    assign w_pick_l  = l_req && !w_pick_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait <= 4'd0;
        end else if (w_grant_go) begin
            if (w_pick_l) begin
                r_wait <= 4'd0;
            end else if (l_req && (r_wait != 4'hF)) begin
                r_wait <= r_wait + 4'd1;
            end
        end
    end
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (MAX_WAIT > 0);
    assign w_pick_c     = c_req;
    assign w_pick_l     = l_req && !c_req;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_OFF: begin
                if (ram_ready) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (!ram_ready) begin
                    w_state_nxt = ST_OFF;
                end else if (w_slot_start && (c_req || l_req)) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_done) w_state_nxt = ST_WAIT;
            end
            default: w_state_nxt = ST_OFF;
        endcase
    end

    // Slot datapath: sd_* only changes on a slot start, so it is stable all slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clkref_d <= 1'b0;
            r_cnt      <= 4'd0;
            r_sd_addr  <= 25'd0;
            r_sd_we    <= 1'b0;
            r_sd_aux   <= 1'b0;
            r_sd_din   <= 8'd0;
            r_c_dout   <= 16'd0;
            r_l_dout   <= 16'd0;
            r_c_ack    <= 1'b0;
            r_l_ack    <= 1'b0;
            r_busy     <= 1'b0;
            r_grant    <= GNT_NONE;
        end else begin
            r_clkref_d <= clkref;
            r_c_ack    <= 1'b0;
            r_l_ack    <= 1'b0;
            if (w_grant_go) begin
                r_cnt <= 4'd0;
                if (w_pick_c) begin
                    r_sd_addr <= c_addr;
                    r_sd_we   <= c_we;
                    r_sd_aux  <= c_aux;
                    r_sd_din  <= c_din;
                    r_grant   <= GNT_CORE;
                    r_busy    <= 1'b1;
                end else if (w_pick_l) begin
                    r_sd_addr <= l_addr;
                    r_sd_we   <= l_we;
                    r_sd_aux  <= l_aux;
                    r_sd_din  <= l_din;
                    r_grant   <= GNT_LDR;
                    r_busy    <= 1'b1;
                end else begin
                    r_sd_we   <= 1'b0;
                    r_grant   <= GNT_NONE;
                end
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt + 4'd1;
                if (w_done) begin
                    if (r_grant == GNT_CORE) begin
                        r_c_dout <= sd_dout;
                        r_c_ack  <= 1'b1;
                    end else begin
                        r_l_dout <= sd_dout;
                        r_l_ack  <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_grant <= GNT_NONE;
                end
            end
        end
    end

    assign sd_addr = r_sd_addr;
    assign sd_we   = r_sd_we;
    assign sd_aux  = r_sd_aux;
    assign sd_din  = r_sd_din;
    assign c_dout  = r_c_dout;
    assign l_dout  = r_l_dout;
    assign c_ack   = r_c_ack;
    assign l_ack   = r_l_ack;
    assign busy    = r_busy;
    assign grant   = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
// ============================================================================
// Module      : tb_sdram_arbiter
// Description : Directed self-checking bench for sdram_arbiter with an
//               ack scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdram_arbiter;

    localparam int DATA_DLY = 6;
    localparam int MAX_WAIT = 4;
    localparam int ACK_PH   = DATA_DLY + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clkref = 1'b0;
    logic        ram_ready = 1'b0;
    logic        c_req = 1'b0, c_we = 1'b0, c_aux = 1'b0;
    logic [24:0] c_addr = '0;
    logic [7:0]  c_din = '0;
    logic [15:0] c_dout;
    logic        c_ack;
    logic        l_req = 1'b0, l_we = 1'b0, l_aux = 1'b0;
    logic [24:0] l_addr = '0;
    logic [7:0]  l_din = '0;
    logic [15:0] l_dout;
    logic        l_ack;
    logic [24:0] sd_addr;
    logic        sd_we, sd_aux;
    logic [7:0]  sd_din;
    logic [15:0] sd_dout = '0;
    logic        busy;
    logic [1:0]  grant;

    int          ph = 0;
    logic [15:0] data_val = 16'h0;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        bit          port;
        bit          chk;
        logic [15:0] dout;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    sdram_arbiter #(.DATA_DLY(DATA_DLY), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .clkref(clkref), .ram_ready(ram_ready),
        .c_req(c_req), .c_addr(c_addr), .c_we(c_we), .c_aux(c_aux),
        .c_din(c_din), .c_dout(c_dout), .c_ack(c_ack),
        .l_req(l_req), .l_addr(l_addr), .l_we(l_we), .l_aux(l_aux),
        .l_din(l_din), .l_dout(l_dout), .l_ack(l_ack),
        .sd_addr(sd_addr), .sd_we(sd_we), .sd_aux(sd_aux), .sd_din(sd_din),
        .sd_dout(sd_dout), .busy(busy), .grant(grant)
    );

    initial forever #5 clk = ~clk;

    // 14-cycle slot reference; ph is the cycle index within the slot
    // and the controller presents read data only in the capture cycle
    initial forever begin
        @(posedge clk);
        #1;
        ph      = (ph == 13) ? 0 : ph + 1;
        clkref  = (ph < 7);
        sd_dout = (ph == DATA_DLY + 1) ? data_val : (16'hDE00 | 16'(ph));
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_cyc(input int n);
        do begin
            @(posedge clk);
            #2;
        end while (ph != n);
    endtask

    task automatic push(input bit port, input bit do_chk, input logic [15:0] d);
        exp_t x;
        x.port = port;
        x.chk  = do_chk;
        x.dout = d;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (!reset && (c_ack || l_ack)) begin
            if (sb.size() == 0) begin
                chk("spurious_ack", {30'd0, l_ack, c_ack}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_port", {30'd0, l_ack, c_ack}, e.port ? 32'd2 : 32'd1);
                chk("ack_cycle", ph, ACK_PH);
                if (e.chk) chk("ack_dout", e.port ? l_dout : c_dout, e.dout);
            end
        end
    end

    initial begin
        // reset values
        wait_cyc(5);
        chk("rst_sd_addr", sd_addr, 0);
        chk("rst_sd_we", sd_we, 0);
        chk("rst_sd_aux", sd_aux, 0);
        chk("rst_sd_din", sd_din, 0);
        chk("rst_c_dout", c_dout, 0);
        chk("rst_l_dout", l_dout, 0);
        chk("rst_acks", {c_ack, l_ack}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        reset  = 1'b0;

        // ram not ready: request must be ignored
        c_req  = 1'b1;
        c_addr = 25'h55;
        repeat (3) begin
            wait_cyc(1);
            chk("notready_grant", grant, 0);
            chk("notready_busy", busy, 0);
        end
        wait_cyc(3);
        ram_ready = 1'b1;
        data_val  = 16'h1111;
        push(1'b0, 1'b1, 16'h1111);
        wait_cyc(1);
        chk("ready_grant", grant, 2'b01);
        chk("ready_sd_addr", sd_addr, 25'h55);
        wait_cyc(ACK_PH);

        // core read
        c_addr   = 25'h00123;
        c_we     = 1'b0;
        c_din    = 8'h77;
        data_val = 16'hA55A;
        push(1'b0, 1'b1, 16'hA55A);
        wait_cyc(1);
        chk("rd_sd_addr", sd_addr, 25'h00123);
        chk("rd_sd_we", sd_we, 0);
        chk("rd_busy", busy, 1);
        chk("rd_grant", grant, 2'b01);
        wait_cyc(5);
        chk("rd_sd_addr_hold", sd_addr, 25'h00123);
        wait_cyc(7);
        chk("rd_dout_before", c_dout, 16'h1111);
        wait_cyc(ACK_PH);
        chk("rd_dout", c_dout, 16'hA55A);
        chk("rd_busy_end", busy, 0);
        chk("rd_grant_end", grant, 0);
        c_req = 1'b0;

        // loader write
        l_req    = 1'b1;
        l_addr   = 25'h1ABCDE;
        l_we     = 1'b1;
        l_din    = 8'h3C;
        l_aux    = 1'b1;
        data_val = 16'h5A5A;
        push(1'b1, 1'b0, 16'h0);
        wait_cyc(1);
        chk("wr_sd_we", sd_we, 1);
        chk("wr_sd_din", sd_din, 8'h3C);
        chk("wr_sd_aux", sd_aux, 1);
        chk("wr_sd_addr", sd_addr, 25'h1ABCDE);
        chk("wr_grant", grant, 2'b10);
        wait_cyc(7);
        chk("wr_hold", {sd_we, sd_aux, sd_din}, {1'b1, 1'b1, 8'h3C});
        chk("wr_grant_hold", grant, 2'b10);
        wait_cyc(ACK_PH);
        chk("wr_c_dout_hold", c_dout, 16'hA55A);
        l_req = 1'b0;
        l_we  = 1'b0;
        l_aux = 1'b0;

        // idle slot with a late core request
        wait_cyc(1);
        chk("idle_grant", grant, 0);
        chk("idle_sd_we", sd_we, 0);
        chk("idle_busy", busy, 0);
        wait_cyc(3);
        c_req  = 1'b1;
        c_addr = 25'h0AAAA;
        c_we   = 1'b1;
        c_din  = 8'h99;
        push(1'b0, 1'b0, 16'h0);
        wait_cyc(5);
        chk("late_grant", grant, 0);
        chk("late_busy", busy, 0);
        wait_cyc(1);
        chk("late_grant_next", grant, 2'b01);
        chk("late_sd", {sd_we, sd_din, sd_addr}, {1'b1, 8'h99, 25'h0AAAA});
        wait_cyc(ACK_PH);

        // contention: both ports held
        c_addr = 25'h10;
        c_we   = 1'b0;
        l_req  = 1'b1;
        l_addr = 25'h20;
        for (int i = 0; i < 10; i++) begin
            bit win_l;
`ifdef SDRAM_ARB_FAIR_EN
            win_l = ((i % 5) == 4);
`else
            win_l = 1'b0;
`endif
            data_val = 16'h1000 + 16'(i);
            push(win_l, 1'b1, 16'h1000 + 16'(i));
            wait_cyc(1);
            chk("cont_grant", grant, win_l ? 2'b10 : 2'b01);
            chk("cont_sd_addr", sd_addr, win_l ? 25'h20 : 25'h10);
            wait_cyc(9);
        end
        c_req = 1'b0;
        l_req = 1'b0;

        // reset in the middle of a granted read
        c_req    = 1'b1;
        c_addr   = 25'h333;
        data_val = 16'hBEEF;
        wait_cyc(1);
        chk("mid_grant", grant, 2'b01);
        wait_cyc(4);
        reset = 1'b1;
        #1;
        chk("mid_rst_sd", {sd_addr, sd_we, sd_aux, sd_din}, 0);
        chk("mid_rst_dout", {c_dout, l_dout}, 0);
        chk("mid_rst_ctl", {c_ack, l_ack, busy, grant}, 0);
        wait_cyc(6);
        reset = 1'b0;
        push(1'b0, 1'b1, 16'hBEEF);
        wait_cyc(1);
        chk("post_rst_grant", grant, 2'b01);
        chk("post_rst_sd_addr", sd_addr, 25'h333);
        wait_cyc(ACK_PH);
        c_req = 1'b0;

        // ram_ready drops mid-slot: slot completes, then no grants
        c_req    = 1'b1;
        c_addr   = 25'h777;
        data_val = 16'h4242;
        push(1'b0, 1'b1, 16'h4242);
        wait_cyc(1);
        chk("drop_grant", grant, 2'b01);
        wait_cyc(3);
        ram_ready = 1'b0;
        wait_cyc(ACK_PH);
        wait_cyc(1);
        chk("drop_after_grant", grant, 0);
        chk("drop_after_busy", busy, 0);
        wait_cyc(ACK_PH);
        c_req = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        chk("pending_acks", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
